// File: rtl/alu_seq.sv
// alu_seq: sequences one wide command through an external 8-bit ALU, LSB byte first,
// and returns the assembled result and flags over a valid/ready response port.
`default_nettype none

module alu_seq #(
  parameter  int NBYTES = 4,
  localparam int W      = 8 * NBYTES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_sel,
  input  logic         cmd_cin,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic         rsp_c,
  output logic         rsp_n,
  output logic         rsp_v,
  output logic         rsp_z,
  output logic         alu_s2,
  output logic         alu_s1,
  output logic         alu_s0,
  output logic         alu_cin,
  output logic [7:0]   alu_a,
  output logic [7:0]   alu_b,
  input  logic [7:0]   alu_op,
  input  logic         alu_c,
  input  logic         alu_v
);

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [2:0]    sel_r;
  logic          cin_r;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic [W-1:0]  result;
  logic          carry_r;
  logic          zacc;
  logic          fc;
  logic          fv;

  logic          run;
  logic          done;
  logic [IW+2:0] bit_base;

  assign run      = (state == RUN);
  assign done     = (state == DONE);
  assign bit_base = {idx, 3'b000};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      sel_r   <= '0;
      cin_r   <= 1'b0;
      a_r     <= '0;
      b_r     <= '0;
      result  <= '0;
      carry_r <= 1'b0;
      zacc    <= 1'b0;
      fc      <= 1'b0;
      fv      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            sel_r  <= cmd_sel;
            cin_r  <= cmd_cin;
            a_r    <= cmd_a;
            b_r    <= cmd_b;
            result <= '0;
            zacc   <= 1'b1;
            idx    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          result[bit_base +: 8] <= alu_op;
          carry_r               <= alu_c;
          zacc                  <= zacc & (alu_op == 8'd0);
          if (idx == LAST) begin
            fc    <= alu_c;
            fv    <= alu_v;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd_ready = (state == IDLE);

  // In logic mode the carry-in is a function select, so it never chains.
  assign alu_cin = run & ((sel_r[2] || idx == '0) ? cin_r : carry_r);
  assign alu_a   = run ? a_r[bit_base +: 8] : 8'd0;
  assign alu_b   = run ? b_r[bit_base +: 8] : 8'd0;
  assign alu_s2  = run & sel_r[2];
  assign alu_s1  = run & sel_r[1];
  assign alu_s0  = run & sel_r[0];

  assign rsp_valid = done;
  assign rsp_data  = done ? result : '0;
  assign rsp_n     = done & result[W-1];
  assign rsp_z     = done & zacc;
  assign rsp_c     = done & ~sel_r[2] & fc;
  assign rsp_v     = done & ~sel_r[2] & fv;

endmodule

`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Multi-byte operation sequencer that sits in front of the 8-bit ALU and also consumes its results.
- Accepts one wide command (operands of 8*NBYTES bits plus ALU selects) over a valid/ready handshake.
- Drives the ALU one byte per cycle, LSB first, chaining carry between bytes in arithmetic mode.
- Assembles the wide result and aggregate flags, then returns them over a second valid/ready handshake.

Parameters:
NBYTES, 4, number of 8-bit slices per operand; legal range 2..8; W = 8*NBYTES

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  sequencer can accept a command
cmd_sel  in  3  {s2,s1,s0} ALU select, captured on accept
cmd_cin  in  1  carry-in (arith) or logic function select (logic)
cmd_a  in  W  operand A
cmd_b  in  W  operand B
rsp_valid  out  1  result available
rsp_ready  in  1  consumer takes result
rsp_data  out  W  assembled result
rsp_c  out  1  carry flag
rsp_n  out  1  negative flag
rsp_v  out  1  overflow flag
rsp_z  out  1  zero flag
alu_s2, alu_s1, alu_s0  out  1 each  ALU select drive
alu_cin  out  1  ALU carry-in drive
alu_a, alu_b  out  8 each  ALU operand byte drive
alu_op  in  8  ALU result byte
alu_c, alu_v  in  1 each  ALU carry and overflow outputs

Behaviour:
- States: IDLE, RUN, DONE. Reset forces IDLE, byte index = 0, and clears all result and flag registers.
- Reset values of outputs:
  - rsp_valid = 0; rsp_data = 0; rsp_c, rsp_n, rsp_v, rsp_z = 0.
  - ALU drives all 0.
  - cmd_ready = 1, because it is decoded from IDLE. Commands are ignored while rst_n is low.
- cmd_ready = (state == IDLE). It is combinational from state only and has no dependency on cmd_valid.
- IDLE:
  - cmd_valid & cmd_ready at an edge captures cmd_sel, cmd_cin, cmd_a and cmd_b.
  - The same edge clears the result register, sets the zero accumulator to 1 and moves to RUN with index 0.
- RUN, cycle k (k = 0..NBYTES-1):
  - ALU drive: alu_a = A[8k+7:8k]; alu_b = B[8k+7:8k]; alu_s2/s1/s0 = captured sel.
  - Arithmetic mode (sel[2] = 0): alu_cin = captured cin when k = 0, otherwise the carry registered from byte k-1.
  - Logic mode (sel[2] = 1): alu_cin = captured cin for every byte, because it is the function select.
  - At the end of the cycle: result[8k+7:8k] <= alu_op; carry_reg <= alu_c; zacc <= zacc & (alu_op == 0).
  - On the last byte (k = NBYTES-1), also latch alu_c and alu_v as final flags and move to DONE. Otherwise k increments.
- The ALU is purely combinational, so there is exactly one ALU evaluation per RUN cycle.
- DONE:
  - rsp_valid = 1 and rsp_data = assembled result.
  - rsp_n = rsp_data[W-1]; rsp_z = zacc.
  - rsp_c and rsp_v: final-byte alu_c and alu_v in arithmetic mode; forced to 0 in logic mode.
  - All rsp_* outputs are held stable until rsp_valid & rsp_ready at an edge, then the state returns to IDLE.
- ALU drive outputs are 0 in IDLE and DONE.
- Latency: a command accepted at edge T produces rsp_valid high after edge T+NBYTES.
  - With rsp_ready held high, throughput is one command per NBYTES+2 cycles.
  - Commands never overlap.
- rsp_ready high while no response is pending has no effect. cmd_valid asserted outside IDLE is not accepted and must be held by the producer.
- Reset asserted mid-RUN or mid-DONE aborts immediately. All outputs return to reset values and the partial result is discarded.
- Widths: no sign extension. Result wraps modulo 2^W, and the carry out of the top byte appears only on rsp_c.

Test Plan:
- NBYTES=4 add, sel=001, cin=0, A=0x000000FF, B=0x00000001 -> rsp_data=0x00000100, C=0, N=0, Z=0; rsp_valid rises 4 cycles after accept.
- Add wrap, sel=001, cin=0, A=0xFFFFFFFF, B=0x00000001 -> rsp_data=0x00000000, C=1, Z=1, N=0; alu_cin=1 observed on bytes 1..3.
- Subtract, sel=010, cin=1, A=0x00000005, B=0x00000007 -> rsp_data=0xFFFFFFFE, C=0, N=1, Z=0.
- Logic XOR, sel=101, cin=0, A=0xF0F0F0F0, B=0xFF00FF00 -> rsp_data=0x0FF00FF0, C=0, V=0, N=0, Z=0; alu_cin=0 on all bytes.
- Backpressure: hold rsp_ready=0 for 5 cycles in DONE -> rsp_* stable and cmd_ready=0 throughout; cmd_ready=1 the cycle after the handshake edge.
- Drop rst_n during RUN byte 2 -> rsp_valid=0, rsp_data=0, ALU drives 0 immediately; after release, a fresh add of 1+1 returns 0x00000002.
